// File: rtl/mult_sequencer.sv
// Control FSM for the iterative shift-add MULTU datapath and the HiLo pair:
// sequences load, ITER step cycles and one HiLo write, and stalls dependent ops.
module mult_sequencer #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic             abort,
    output logic             mul_load,
    output logic             mul_step,
    output logic             hilo_we,
    output logic             busy,
    output logic             stall,
    output logic [1:0]       sel_hilo,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WRITE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_is_multu;
    logic             w_is_mfhi;
    logic             w_is_mflo;

    assign w_is_multu = op_valid && (funct == FN_MULTU);
    assign w_is_mfhi  = op_valid && (funct == FN_MFHI);
    assign w_is_mflo  = op_valid && (funct == FN_MFLO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
        end
    end

    // Counter is only non-zero while staying in RUN, so step_count reads 0 elsewhere.
    always_comb begin
        w_next       = r_state;
        w_count_next = '0;
        case (r_state)
            S_IDLE: begin
                if (w_is_multu && !abort) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_count == CNT_W'(ITER - 1)) begin
                    w_next = S_WRITE;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            S_WRITE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mul_load   = (r_state == S_LOAD);
        mul_step   = (r_state == S_RUN);
        hilo_we    = (r_state == S_WRITE);
        busy       = (r_state != S_IDLE);
        step_count = r_count;
        stall      = busy && (w_is_multu || w_is_mfhi || w_is_mflo);
        sel_hilo   = 2'b00;
        if (!stall) begin
            if (w_is_mfhi)      sel_hilo = 2'b01;
            else if (w_is_mflo) sel_hilo = 2'b10;
        end
    end

endmodule
